// File: rtl/id_ex_stage_register_if.sv
// ID/EX boundary bundle: decoder-side control word and operands in, EX-side registered copies,
// hazard stall and bubble counter out. The master drives ID, the slave is the stage register.
interface id_ex_stage_register_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            stall_in;
  logic            flush_in;
  logic            ID_valid;
  logic            ID_load_Instr;
  logic            ID_RF_enable;
  logic            RAM_Enable;
  logic            RAM_RW;
  logic            RAM_SE;
  logic [1:0]      RAM_Size;
  logic            jump_instr;
  logic            JAL_Instr;
  logic            JALR_Instr;
  logic            AUIPC_Instr;
  logic [3:0]      ID_ALU_op;
  logic [2:0]      ID_shift_imm;
  logic [9:0]      Comb_OpFunct;
  logic [XLEN-1:0] ID_pc;
  logic [XLEN-1:0] ID_rs1_data;
  logic [XLEN-1:0] ID_rs2_data;
  logic [XLEN-1:0] ID_imm;
  logic [4:0]      ID_rs1;
  logic [4:0]      ID_rs2;
  logic [4:0]      ID_rd;
  logic            ID_use_rs1;
  logic            ID_use_rs2;

  logic            EX_valid;
  logic            EX_load_Instr;
  logic            EX_RF_enable;
  logic            EX_RAM_Enable;
  logic            EX_RAM_RW;
  logic            EX_RAM_SE;
  logic [1:0]      EX_RAM_Size;
  logic            EX_jump_instr;
  logic            EX_JAL_Instr;
  logic            EX_JALR_Instr;
  logic            EX_AUIPC_Instr;
  logic [3:0]      EX_ALU_op;
  logic [2:0]      EX_shift_imm;
  logic [9:0]      EX_Comb_OpFunct;
  logic [XLEN-1:0] EX_pc;
  logic [XLEN-1:0] EX_rs1_data;
  logic [XLEN-1:0] EX_rs2_data;
  logic [XLEN-1:0] EX_imm;
  logic [4:0]      EX_rs1;
  logic [4:0]      EX_rs2;
  logic [4:0]      EX_rd;
  logic            EX_use_rs1;
  logic            EX_use_rs2;
  logic            hazard_stall;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output stall_in, flush_in, ID_valid, ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW,
           RAM_SE, RAM_Size, jump_instr, JAL_Instr, JALR_Instr, AUIPC_Instr, ID_ALU_op,
           ID_shift_imm, Comb_OpFunct, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm, ID_rs1,
           ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
    input  EX_valid, EX_load_Instr, EX_RF_enable, EX_RAM_Enable, EX_RAM_RW, EX_RAM_SE,
           EX_RAM_Size, EX_jump_instr, EX_JAL_Instr, EX_JALR_Instr, EX_AUIPC_Instr, EX_ALU_op,
           EX_shift_imm, EX_Comb_OpFunct, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm, EX_rs1,
           EX_rs2, EX_rd, EX_use_rs1, EX_use_rs2, hazard_stall, bubble_count
  );

  modport slave (
    input  stall_in, flush_in, ID_valid, ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW,
           RAM_SE, RAM_Size, jump_instr, JAL_Instr, JALR_Instr, AUIPC_Instr, ID_ALU_op,
           ID_shift_imm, Comb_OpFunct, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm, ID_rs1,
           ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
    output EX_valid, EX_load_Instr, EX_RF_enable, EX_RAM_Enable, EX_RAM_RW, EX_RAM_SE,
           EX_RAM_Size, EX_jump_instr, EX_JAL_Instr, EX_JALR_Instr, EX_AUIPC_Instr, EX_ALU_op,
           EX_shift_imm, EX_Comb_OpFunct, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm, EX_rs1,
           EX_rs2, EX_rd, EX_use_rs1, EX_use_rs2, hazard_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on hazard or flush,
// and a saturating counter of inserted bubbles.
module id_ex_stage_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  id_ex_stage_register_if.slave bus
);
  // Control flags/fields (28) + four XLEN words + three register indices (15) + two use flags.
  localparam int WORD_W = 45 + 4 * XLEN;

  logic [WORD_W-1:0] id_word;
  logic [WORD_W-1:0] ex_word_reg;
  logic              ex_valid_reg;
  logic [CNT_W-1:0]  bubble_count_reg;
  logic              load_use;
  logic              src_match;

  assign id_word = {bus.ID_load_Instr, bus.ID_RF_enable, bus.RAM_Enable, bus.RAM_RW, bus.RAM_SE,
                    bus.RAM_Size, bus.jump_instr, bus.JAL_Instr, bus.JALR_Instr, bus.AUIPC_Instr,
                    bus.ID_ALU_op, bus.ID_shift_imm, bus.Comb_OpFunct, bus.ID_pc,
                    bus.ID_rs1_data, bus.ID_rs2_data, bus.ID_imm, bus.ID_rs1, bus.ID_rs2,
                    bus.ID_rd, bus.ID_use_rs1, bus.ID_use_rs2};

  assign {bus.EX_load_Instr, bus.EX_RF_enable, bus.EX_RAM_Enable, bus.EX_RAM_RW, bus.EX_RAM_SE,
          bus.EX_RAM_Size, bus.EX_jump_instr, bus.EX_JAL_Instr, bus.EX_JALR_Instr,
          bus.EX_AUIPC_Instr, bus.EX_ALU_op, bus.EX_shift_imm, bus.EX_Comb_OpFunct, bus.EX_pc,
          bus.EX_rs1_data, bus.EX_rs2_data, bus.EX_imm, bus.EX_rs1, bus.EX_rs2, bus.EX_rd,
          bus.EX_use_rs1, bus.EX_use_rs2} = ex_word_reg;

  assign bus.EX_valid     = ex_valid_reg;
  assign bus.bubble_count = bubble_count_reg;

  // Only EX state and ID indices feed the hazard: no ID data reaches EX combinationally.
  assign src_match = (bus.ID_use_rs1 && (bus.ID_rs1 == bus.EX_rd)) ||
                     (bus.ID_use_rs2 && (bus.ID_rs2 == bus.EX_rd));
  assign load_use  = ex_valid_reg && bus.EX_load_Instr && (bus.EX_rd != 5'd0) &&
                     src_match && bus.ID_valid;
  assign bus.hazard_stall = load_use && !bus.flush_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_word_reg      <= '0;
      ex_valid_reg     <= 1'b0;
      bubble_count_reg <= '0;
    end else if (bus.flush_in || (!bus.stall_in && load_use)) begin
      ex_word_reg  <= '0;
      ex_valid_reg <= 1'b0;
      if (bubble_count_reg != {CNT_W{1'b1}})
        bubble_count_reg <= bubble_count_reg + CNT_W'(1);
    end else if (!bus.stall_in) begin
      ex_word_reg  <= id_word;
      ex_valid_reg <= bus.ID_valid;
    end
  end
endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder.
- Each cycle it latches the decoder control word plus the operand data for the EX stage.
- It also detects load-use hazards, inserts bubbles on hazard or flush, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
CNT_W, 16, width of bubble performance counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall_in  in  1  external stall: hold EX contents
flush_in  in  1  branch/jump flush: load bubble
ID_valid  in  1  ID holds a real instruction
ID_load_Instr  in  1  decoder load flag
ID_RF_enable  in  1  register-file write enable
RAM_Enable  in  1  memory access enable
RAM_RW  in  1  1 = store
RAM_SE  in  1  load sign-extend
RAM_Size  in  2  access size
jump_instr, JAL_Instr, JALR_Instr, AUIPC_Instr  in  1 each  decoder flow flags
ID_ALU_op  in  4  ALU operation
ID_shift_imm  in  3  immediate/shifter select
Comb_OpFunct  in  10  {opcode, funct3}
ID_pc  in  XLEN  instruction PC
ID_rs1_data, ID_rs2_data, ID_imm  in  XLEN each  operands / immediate
ID_rs1, ID_rs2, ID_rd  in  5 each  register indices
ID_use_rs1, ID_use_rs2  in  1 each  instruction reads rs1/rs2
EX_* (one per ID/RAM/flag/data input above)  out  same width  registered copies, EX_ prefix on every name
EX_valid  out  1  EX holds a real instruction
hazard_stall  out  1  combinational; freeze PC and IF/ID
bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset, asynchronous on rst_n low: every EX_* output = 0, EX_valid = 0, bubble_count = 0.
- A bubble is all EX_* control and data fields = 0 with EX_valid = 0. All-zero ALU op, RF enable and RAM enable is the NOP encoding.
- Hazard detect (combinational):
  - load_use = EX_valid & EX_load_Instr & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1 == EX_rd) | (ID_use_rs2 & ID_rs2 == EX_rd)) & ID_valid.
  - hazard_stall = load_use & ~flush_in.
- Register update priority per rising edge, highest first:
  1. flush_in = 1: load bubble. Counted. Overrides stall_in and hazard.
  2. stall_in = 1: hold all EX_* and EX_valid. No count.
  3. load_use = 1: load bubble. Counted. The ID instruction is not captured; upstream holds it via hazard_stall.
  4. Otherwise: capture all ID inputs; EX_valid = ID_valid.
- Capturing an ID_valid = 0 instruction on path 4 is not counted as a bubble.
- Latency is one cycle ID to EX. The next cycle after a load-use bubble carries EX_valid = 0, so load_use clears and the held instruction is captured on the following edge. Net penalty is exactly one cycle.
- Load followed by back-to-back dependent instructions: only the first dependent instruction stalls.
- EX_rd = 0 never triggers a hazard.
- bubble_count:
  - Increments by 1 on each counted bubble.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset asserted mid-stall or mid-hazard: outputs clear immediately. hazard_stall drops because EX_valid = 0.
- flush_in and stall_in together: flush wins; EX becomes a bubble.
- No combinational path from ID_* data inputs to EX_* outputs. hazard_stall is the only combinational output.

Test Plan:
- Reset: rst_n low mid-cycle with EX loaded by ADD -> all EX_* = 0, EX_valid = 0, bubble_count = 0 without waiting for a clock edge.
- Normal flow: ADDI x5,x4,0 (ALU_op 0010, RF_enable 1, shift_imm 001, PC 0x10) -> next edge EX_ALU_op = 0010, EX_rd = 5, EX_pc = 0x10, EX_valid = 1.
- Load-use: LB x2,0(x1) in EX, then ADD x3,x2,x1 in ID with use_rs1 = 1 ->
  - hazard_stall = 1 for exactly one cycle;
  - EX becomes a bubble; bubble_count = 1;
  - ADD appears in EX one cycle later.
- No hazard on x0 or unused source: LB x0 followed by ADD x3,x0,x1, and LB x2 followed by JAL (use_rs1 = use_rs2 = 0) -> hazard_stall = 0 in both cases.
- Stall vs flush: stall_in = 1 for 3 cycles -> EX_* unchanged, count unchanged. flush_in = 1 together with stall_in = 1 -> bubble, count +1, hazard_stall forced 0.
- Saturation (CNT_W = 4): 20 consecutive flushes -> bubble_count stops at 15.
